// File: rtl/lzc_norm_arbiter_if.sv
// Request/result bus of the shared leading-zero-count / normalize unit.
// The master drives requests and consumes results; the slave is the arbiter.
interface lzc_norm_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int MW      = 16,
   parameter int EW      = 6
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*MW-1:0] req_mant;
   logic [NUM_REQ*EW-1:0] req_exp;
   logic [NUM_REQ-1:0]    req_ready;

   logic                  out_valid;
   logic                  out_ready;
   logic [ID_W-1:0]       out_id;
   logic [MW-1:0]         out_mant;
   logic [EW-1:0]         out_exp;
   logic                  out_zero;
   logic                  out_uflow;
   logic                  busy;

   modport master (
      output req_valid, req_mant, req_exp, out_ready,
      input  req_ready, out_valid, out_id, out_mant, out_exp, out_zero, out_uflow, busy
   );

   modport slave (
      input  req_valid, req_mant, req_exp, out_ready,
      output req_ready, out_valid, out_id, out_mant, out_exp, out_zero, out_uflow, busy
   );
endinterface

// File: rtl/lzc_norm_arbiter.sv
// Round-robin shared normalizer: one grant per cycle into a 2-stage pipeline
// (S1 captures the request, S2 holds the normalized, ID-tagged result).
module lzc_norm_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int MW      = 16,
   parameter int EW      = 6
) (
   input logic               clk,
   input logic               resetn,
   lzc_norm_arbiter_if.slave bus
);

   localparam int CW = $clog2(MW + 1);
   localparam int SW = (CW > EW) ? CW : EW;

   logic [ID_W-1:0] ptr;
   logic            grant_found;
   logic [ID_W-1:0] grant_idx;
   logic            accept;

   logic            adv1;
   logic            adv2;

   logic            s1_valid;
   logic [MW-1:0]   s1_mant;
   logic [EW-1:0]   s1_exp;
   logic [ID_W-1:0] s1_id;

   logic [CW-1:0]   cnt;
   logic [SW-1:0]   cnt_w;
   logic [SW-1:0]   exp_w;
   logic [SW-1:0]   sh;
   logic [MW-1:0]   norm_mant;
   logic [EW-1:0]   norm_exp;
   logic            norm_zero;
   logic            norm_uflow;

   logic            s2_valid;
   logic [ID_W-1:0] s2_id;
   logic [MW-1:0]   s2_mant;
   logic [EW-1:0]   s2_exp;
   logic            s2_zero;
   logic            s2_uflow;

   // ---------------------------------------------------------------- stall
   assign adv2 = !s2_valid || bus.out_ready;
   assign adv1 = !s1_valid || adv2;

   // ------------------------------------------------------------- arbiter
   // Search upward from the pointer; NUM_REQ == 2**ID_W so the add wraps.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && bus.req_valid[ptr + ID_W'(k)]) begin
            grant_found = 1'b1;
            grant_idx   = ptr + ID_W'(k);
         end
      end
   end

   assign accept = resetn && grant_found && adv1;

   always_comb begin
      bus.req_ready = '0;
      if (accept) begin
         bus.req_ready[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!resetn) begin
         ptr <= '0;
      end else if (accept) begin
         ptr <= grant_idx + ID_W'(1);
      end
   end

   // ------------------------------------------------------------ stage 1
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
      end else if (adv1) begin
         s1_valid <= accept;
      end
   end

   // NOTE: S1 payload sits behind s1_valid and is never observed while invalid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_mant <= bus.req_mant[int'(grant_idx) * MW +: MW];
         s1_exp  <= bus.req_exp[int'(grant_idx) * EW +: EW];
         s1_id   <= grant_idx;
      end
   end

   // ------------------------------------------------ leading-zero / shift
   // Highest set bit wins because later iterations overwrite earlier ones.
   always_comb begin
      cnt = CW'(MW);
      for (int b = 0; b < MW; b++) begin
         if (s1_mant[b]) begin
            cnt = CW'(MW - 1 - b);
         end
      end
   end

   assign cnt_w      = SW'(cnt);
   assign exp_w      = SW'(s1_exp);
   assign sh         = (cnt_w < exp_w) ? cnt_w : exp_w;
   assign norm_zero  = (s1_mant == '0);
   assign norm_mant  = s1_mant << sh;
   assign norm_exp   = norm_zero ? '0 : s1_exp - EW'(sh);
   assign norm_uflow = (cnt_w > exp_w) && !norm_zero;

   // ------------------------------------------------------------ stage 2
   // Output registers are reset because they drive the ports directly.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s2_valid <= 1'b0;
         s2_id    <= '0;
         s2_mant  <= '0;
         s2_exp   <= '0;
         s2_zero  <= 1'b0;
         s2_uflow <= 1'b0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_id    <= s1_id;
            s2_mant  <= norm_mant;
            s2_exp   <= norm_exp;
            s2_zero  <= norm_zero;
            s2_uflow <= norm_uflow;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.out_id    = s2_id;
   assign bus.out_mant  = s2_mant;
   assign bus.out_exp   = s2_exp;
   assign bus.out_zero  = s2_zero;
   assign bus.out_uflow = s2_uflow;
   assign bus.busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_lzc_norm_arbiter.sv
// Self-checking bench for lzc_norm_arbiter: scoreboard of expected results
// pushed on each accepted request and popped on each delivered result.
module tb_lzc_norm_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int MW      = 16;
   localparam int EW      = 6;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [MW-1:0]   mant;
      logic [EW-1:0]   exp;
      logic            zero;
      logic            uflow;
   } result_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   lzc_norm_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MW(MW), .EW(EW)) bus ();

   lzc_norm_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MW(MW), .EW(EW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int      checks   = 0;
   int      failures = 0;
   result_t sb_q[$];

   // Reference: shift one bit at a time until the MSB is set or the exponent runs out.
   function automatic result_t model(input logic [ID_W-1:0] id, input logic [MW-1:0] m,
                                     input logic [EW-1:0] e);
      result_t r;
      r.id    = id;
      r.zero  = (m == '0);
      r.uflow = 1'b0;
      if (m == '0) begin
         r.mant = '0;
         r.exp  = '0;
      end else begin
         while (!m[MW-1] && e != '0) begin
            m = m << 1;
            e = e - 1'b1;
         end
         r.mant  = m;
         r.exp   = e;
         r.uflow = !m[MW-1];
      end
      return r;
   endfunction

   function automatic result_t cur_out();
      result_t r;
      r.id    = bus.out_id;
      r.mant  = bus.out_mant;
      r.exp   = bus.out_exp;
      r.zero  = bus.out_zero;
      r.uflow = bus.out_uflow;
      return r;
   endfunction

   // Monitor: scoreboard, output hold under stall, one-hot grant, grant fairness.
   logic    prev_stall = 1'b0;
   result_t prev_out;
   int      wait_cnt[NUM_REQ];

   always @(negedge clk) begin
      result_t cur;
      result_t exp_r;
      logic [NUM_REQ-1:0] acc;
      cur = cur_out();
      acc = bus.req_valid & bus.req_ready;
      if (!resetn) begin
         sb_q.delete();
         prev_stall = 1'b0;
         for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (cur !== prev_out) begin
               failures++;
               $display("FAIL out_hold got=%h want=%h", cur, prev_out);
            end
         end
         checks++;
         if ($countones(bus.req_ready) > 1) begin
            failures++;
            $display("FAIL ready_onehot got=%b want=at most one bit", bus.req_ready);
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL out_unexpected got=%h want=no result", cur);
            end else begin
               exp_r = sb_q.pop_front();
               if (cur !== exp_r) begin
                  failures++;
                  $display("FAIL out_result got=%h want=%h", cur, exp_r);
               end
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
               checks++;
               if (wait_cnt[i] >= NUM_REQ) begin
                  failures++;
                  $display("FAIL fairness id=%0d got=%0d other grants want<%0d", i, wait_cnt[i], NUM_REQ);
               end
               wait_cnt[i] = 0;
               sb_q.push_back(model(ID_W'(i), bus.req_mant[i*MW +: MW], bus.req_exp[i*EW +: EW]));
            end else if (bus.req_valid[i] && acc != '0) begin
               wait_cnt[i]++;
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_out   = cur;
      end
   end

   // ------------------------------------------------------------ helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [MW-1:0] m, input logic [EW-1:0] e);
      bus.req_valid[i]         = 1'b1;
      bus.req_mant[i*MW +: MW] = m;
      bus.req_exp[i*EW +: EW]  = e;
   endtask

   // Keeps each request asserted until it is accepted, as a requester must.
   task automatic serve_pending(input int budget);
      logic [NUM_REQ-1:0] acc;
      int n = 0;
      while (bus.req_valid != '0 && n < budget) begin
         @(negedge clk);
         acc = bus.req_valid & bus.req_ready;
         tick();
         bus.req_valid = bus.req_valid & ~acc;
         n++;
      end
      checks++;
      if (bus.req_valid != '0) begin
         failures++;
         $display("FAIL serve_timeout got=%b pending want=0", bus.req_valid);
      end
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((sb_q.size() != 0 || bus.busy) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (sb_q.size() != 0 || bus.busy) begin
         failures++;
         $display("FAIL drain_timeout got=%0d queued busy=%b want=0", sb_q.size(), bus.busy);
      end
   endtask

   task automatic run_single(input string name, input int id, input logic [MW-1:0] m,
                             input logic [EW-1:0] e, input result_t want);
      logic [NUM_REQ-1:0] want_rdy;
      want_rdy = '0;
      want_rdy[id] = 1'b1;
      bus.out_ready = 1'b1;
      set_req(id, m, e);
      #1;
      checks++;
      if (bus.req_ready !== want_rdy) begin
         failures++;
         $display("FAIL %s_ready got=%b want=%b", name, bus.req_ready, want_rdy);
      end
      tick();
      bus.req_valid = '0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_early got=%b want=0", name, bus.out_valid);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || cur_out() !== want) begin
         failures++;
         $display("FAIL %s_result got=%b/%h want=1/%h", name, bus.out_valid, cur_out(), want);
      end
      tick();
   endtask

   // -------------------------------------------------------------- tests
   task automatic test_reset();
      resetn        = 1'b0;
      bus.req_valid = '1;
      bus.out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.req_ready !== '0) begin
         failures++;
         $display("FAIL reset_ready got=%b want=0", bus.req_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid_busy got=%b/%b want=0/0", bus.out_valid, bus.busy);
      end
      checks++;
      if (cur_out() !== '0) begin
         failures++;
         $display("FAIL reset_payload got=%h want=0", cur_out());
      end
      bus.req_valid = '0;
      resetn        = 1'b1;
      tick();
   endtask

   task automatic test_single();
      run_single("single", 1, 16'h0010, 6'd20, '{id: 2'd1, mant: 16'h8000, exp: 6'd9, zero: 1'b0, uflow: 1'b0});
   endtask

   task automatic test_zero_uflow();
      run_single("zero", 2, 16'h0000, 6'd7, '{id: 2'd2, mant: 16'h0000, exp: 6'd0, zero: 1'b1, uflow: 1'b0});
      run_single("uflow", 3, 16'h0100, 6'd3, '{id: 2'd3, mant: 16'h0800, exp: 6'd0, zero: 1'b0, uflow: 1'b1});
      run_single("exact", 0, 16'h0001, 6'd15, '{id: 2'd0, mant: 16'h8000, exp: 6'd0, zero: 1'b0, uflow: 1'b0});
      run_single("norm", 1, 16'hC000, 6'd0, '{id: 2'd1, mant: 16'hC000, exp: 6'd0, zero: 1'b0, uflow: 1'b0});
      wait_drain(20);
   endtask

   task automatic test_fairness();
      logic [NUM_REQ-1:0] want_rdy;
      resetn = 1'b0;
      tick();
      resetn        = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'h0001 << (4 * i), 6'(10 + i));
      for (int k = 0; k < 6; k++) begin
         #1;
         want_rdy = '0;
         want_rdy[k % NUM_REQ] = 1'b1;
         checks++;
         if (bus.req_ready !== want_rdy) begin
            failures++;
            $display("FAIL fair_grant%0d got=%b want=%b", k, bus.req_ready, want_rdy);
         end
         tick();
      end
      bus.req_valid = '0;
      wait_drain(20);
   endtask

   task automatic test_backpressure();
      logic [NUM_REQ-1:0] acc;
      int accepts = 0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'h00F0 >> i, 6'(30 - i));
      repeat (5) begin
         @(negedge clk);
         acc = bus.req_valid & bus.req_ready;
         accepts += $countones(acc);
         tick();
         bus.req_valid = bus.req_valid & ~acc;
      end
      checks++;
      if (accepts != 2) begin
         failures++;
         $display("FAIL bp_accepts got=%0d want=2", accepts);
      end
      #1;
      checks++;
      if (bus.req_ready !== '0) begin
         failures++;
         $display("FAIL bp_ready got=%b want=0", bus.req_ready);
      end
      bus.out_ready = 1'b1;
      serve_pending(40);
      wait_drain(40);
   endtask

   task automatic test_reset_midflight();
      int stale = 0;
      bus.out_ready = 1'b0;
      set_req(0, 16'h0123, 6'd40);
      set_req(1, 16'h0456, 6'd41);
      serve_pending(10);
      checks++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_full got=%b/%b want=1/1", bus.busy, bus.out_valid);
      end
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL mid_flush got=%b/%b want=0/0", bus.out_valid, bus.busy);
      end
      bus.out_ready = 1'b1;
      repeat (6) begin
         tick();
         if (bus.out_valid) stale++;
      end
      checks++;
      if (stale != 0) begin
         failures++;
         $display("FAIL mid_stale got=%0d want=0", stale);
      end
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'h0800, 6'd5);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL mid_pointer got=%b want=0001", bus.req_ready);
      end
      serve_pending(20);
      wait_drain(20);
   endtask

   task automatic test_random_soak();
      logic [NUM_REQ-1:0] acc;
      logic [MW-1:0]      m;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         acc = bus.req_valid & bus.req_ready;
         tick();
         bus.req_valid = bus.req_valid & ~acc;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
               case ($urandom_range(0, 3))
                  0:       m = '0;
                  1:       m = MW'(1) << $urandom_range(0, MW - 1);
                  default: m = MW'($urandom);
               endcase
               set_req(i, m, EW'($urandom_range(0, 63)));
            end
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = 1'b1;
      serve_pending(40);
      wait_drain(40);
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_mant  = '0;
      bus.req_exp   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_single();
      test_zero_uflow();
      test_fairness();
      test_backpressure();
      test_reset_midflight();
      test_random_soak();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/lzc_norm_arbiter.md
Name: lzc_norm_arbiter

Overview:
- Shares one 16-bit leading-zero-count plus normalize-shift datapath among NUM_REQ requesters, e.g. the fp16 adder/accumulator lanes of the attention layer.
- A round-robin arbiter picks one request per cycle.
- A 2-stage pipeline computes the leading-zero count, left-shifts the mantissa, and adjusts the exponent.
- The result is returned on a single valid/ready output, tagged with the requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (power of two, 2..8).
- ID_W, 2, requester ID width; equals log2(NUM_REQ).
- MW, 16, mantissa width; the leading-zero count is 0..MW.
- EW, 6, unsigned exponent width, in and out.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_mant  in  NUM_REQ*MW  mantissas; requester i occupies bits [i*MW +: MW].
- req_exp  in  NUM_REQ*EW  exponents; requester i occupies bits [i*EW +: EW].
- req_ready  out  NUM_REQ  one-hot grant/accept; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_id  out  ID_W  requester index of the result.
- out_mant  out  MW  normalized mantissa.
- out_exp  out  EW  adjusted exponent.
- out_zero  out  1  input mantissa was zero.
- out_uflow  out  1  normalization was limited by the exponent.
- busy  out  1  any pipeline stage occupied.

Behaviour:
- One clock; reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset values:
  - all stage valids 0; out_valid 0.
  - out_id, out_mant, out_exp, out_zero, out_uflow all 0.
  - round-robin pointer 0; busy 0.
  - req_ready is 0 during reset.
- Reset asserted mid-operation flushes both stages; in-flight results are dropped, never emitted.
- Pipeline:
  - S1 registers {mant, exp, id} of the granted request.
  - The leading-zero count cnt is computed combinationally from the S1 mantissa. It is 0..MW; MW when the mantissa is 0.
  - S2 registers the normalized result and drives the out_* ports directly.
- Stall/advance:
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - S1→S2 moves when s1_valid & adv2.
  - A new grant is loaded into S1 only when adv1.
- Latency and throughput:
  - Accept in cycle N gives out_valid=1 in cycle N+2 when there is no backpressure.
  - Sustained throughput is 1 result per cycle with out_ready held high.
- Output hold: out_* hold stable while out_valid & !out_ready.
- Arbitration:
  - Search starts at the pointer and goes upward modulo NUM_REQ. The first asserted req_valid is granted.
  - req_ready[g] = adv1 for granted index g; all other bits are 0.
  - req_ready is combinational from req_valid, pointer and adv1.
  - The pointer becomes (g+1) mod NUM_REQ only on an accepted transfer; otherwise it is unchanged.
  - With no req_valid, nothing is granted.
- Requester obligations: hold req_valid and data stable until accepted. The block does not check for retraction.
- Arithmetic, with sh = min(cnt, exp):
  - out_mant = mant << sh, zero-filled, truncated to MW.
  - out_exp = exp − sh.
  - out_uflow = (cnt > exp) & (mant ≠ 0).
  - out_zero = (mant == 0). For a zero mantissa, out_mant=0, out_exp=0 and out_uflow=0.
- Simultaneous events: S1 refill and S1→S2 move in the same cycle are legal and lose no data.
- busy = s1_valid | s2_valid.

Test Plan:
- Single request: req 1 only, mant 0x0010, exp 20 → req_ready[1]=1 in the same cycle; 2 cycles later out_valid=1, out_id=1, out_mant=0x8000, out_exp=9, out_zero=0, out_uflow=0.
- Zero and underflow:
  - mant 0x0000, exp 7 → out_zero=1, out_mant=0, out_exp=0.
  - mant 0x0100, exp 3 → out_mant=0x0800, out_exp=0, out_uflow=1.
- Fairness: all 4 requesters held valid, pointer 0, out_ready=1 → grants 0,1,2,3,0,1 on consecutive cycles; out_id sequence matches 2 cycles later.
- Backpressure:
  - out_ready=0 for 5 cycles with 4 continuous requests → exactly 2 accepts, then all req_ready=0; out_* stable.
  - After out_ready=1 → results drain in grant order with no loss or duplication.
- Reset mid-flight: resetn=0 for 1 cycle with both stages full → next cycle out_valid=0, busy=0, pointer=0; no stale result ever appears.
- Random soak: random valids, data and out_ready for 10k cycles → scoreboard per ID matches the reference normalize model; every request is served within NUM_REQ grants of becoming valid while out_ready=1.
